// File: rtl/commit_trace_monitor_if.sv
// rtl/commit_trace_monitor_if.sv - retirement stream in, trace record stream and status out
interface commit_trace_monitor_if #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             clear_i;
  logic             commit_i;
  logic [31:0]      commit_pc_i;
  logic [31:0]      commit_pre_pc_i;
  logic             trace_valid_o;
  logic             trace_ready_i;
  logic [31:0]      trace_pc_o;
  logic [31:0]      trace_pre_pc_o;
  logic [CNT_W-1:0] trace_seq_o;
  logic [CW-1:0]    fifo_count_o;
  logic [CNT_W-1:0] commit_cnt_o;
  logic [CNT_W-1:0] drop_cnt_o;
  logic             overflow_o;
  logic             flow_err_o;
  logic [31:0]      err_pc_o;
  logic [31:0]      err_exp_pc_o;

  modport slave (
    input  clear_i, commit_i, commit_pc_i, commit_pre_pc_i, trace_ready_i,
    output trace_valid_o, trace_pc_o, trace_pre_pc_o, trace_seq_o, fifo_count_o,
           commit_cnt_o, drop_cnt_o, overflow_o, flow_err_o, err_pc_o, err_exp_pc_o
  );

  modport master (
    output clear_i, commit_i, commit_pc_i, commit_pre_pc_i, trace_ready_i,
    input  trace_valid_o, trace_pc_o, trace_pre_pc_o, trace_seq_o, fifo_count_o,
           commit_cnt_o, drop_cnt_o, overflow_o, flow_err_o, err_pc_o, err_exp_pc_o
  );
endinterface

// File: rtl/commit_trace_monitor.sv
// rtl/commit_trace_monitor.sv - control-flow continuity checker with retirement trace FIFO
module commit_trace_monitor #(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 32
) (
  input logic                    clk,
  input logic                    rst,
  commit_trace_monitor_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {WAIT_FIRST, TRACK, ERROR} state_t;

  state_t           state, state_nxt;
  logic [31:0]      exp_pc;
  logic [CNT_W-1:0] commit_cnt, drop_cnt;
  logic             overflow, flow_err;
  logic [31:0]      err_pc, err_exp_pc;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;

  logic [31:0]      mem_pc  [DEPTH];
  logic [31:0]      mem_pre [DEPTH];
  logic [CNT_W-1:0] mem_seq [DEPTH];

  logic accept, raise, push, pop, drop, full, head_valid;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    raise     = 1'b0;
    if (bus.commit_i) begin
      case (state)
        WAIT_FIRST: begin
          if (bus.commit_pc_i == RESET_PC) begin
            accept    = 1'b1;
            state_nxt = TRACK;
          end else begin
            raise     = 1'b1;
            state_nxt = ERROR;
          end
        end
        TRACK: begin
          if (bus.commit_pc_i == exp_pc) begin
            accept = 1'b1;
          end else begin
            raise     = 1'b1;
            state_nxt = ERROR;
          end
        end
        default: state_nxt = ERROR;
      endcase
    end
  end

  // A full FIFO still takes the record when the head leaves in the same cycle.
  assign head_valid = (count != '0);
  assign full       = (count == FULL_CNT);
  assign pop        = head_valid && bus.trace_ready_i;
  assign push       = accept && (!full || pop);
  assign drop       = accept && full && !pop;

  always_ff @(posedge clk) begin
    if (rst || bus.clear_i) begin
      state      <= WAIT_FIRST;
      exp_pc     <= RESET_PC;
      commit_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
      flow_err   <= 1'b0;
      err_pc     <= '0;
      err_exp_pc <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        exp_pc     <= bus.commit_pre_pc_i;
        commit_cnt <= commit_cnt + CNT_W'(1);
      end
      if (drop) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
        overflow <= 1'b1;
      end
      if (raise) begin
        flow_err   <= 1'b1;
        err_pc     <= bus.commit_pc_i;
        err_exp_pc <= (state == WAIT_FIRST) ? RESET_PC : exp_pc;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]  <= bus.commit_pc_i;
      mem_pre[wr_ptr] <= bus.commit_pre_pc_i;
      mem_seq[wr_ptr] <= commit_cnt;
    end
  end

  // Head fields read as zero while empty so nothing stale is exposed after reset.
  assign bus.trace_valid_o  = head_valid;
  assign bus.trace_pc_o     = head_valid ? mem_pc[rd_ptr]  : '0;
  assign bus.trace_pre_pc_o = head_valid ? mem_pre[rd_ptr] : '0;
  assign bus.trace_seq_o    = head_valid ? mem_seq[rd_ptr] : '0;
  assign bus.fifo_count_o   = count;
  assign bus.commit_cnt_o   = commit_cnt;
  assign bus.drop_cnt_o     = drop_cnt;
  assign bus.overflow_o     = overflow;
  assign bus.flow_err_o     = flow_err;
  assign bus.err_pc_o       = err_pc;
  assign bus.err_exp_pc_o   = err_exp_pc;
endmodule

// File: tb/tb_commit_trace_monitor.sv
// tb/tb_commit_trace_monitor.sv - directed self-checking bench for commit_trace_monitor
module tb_commit_trace_monitor;
  localparam int DEPTH = 16;
  localparam int CNT_W = 32;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  commit_trace_monitor_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  commit_trace_monitor #(.DEPTH(DEPTH), .RESET_PC(BASE), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.clear_i = 1'b0;
    bus.commit_i = 1'b0;
    bus.trace_ready_i = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] pre);
    bus.commit_i = 1'b1;
    bus.commit_pc_i = pc;
    bus.commit_pre_pc_i = pre;
    step();
    bus.commit_i = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] pc, input logic [31:0] pre,
                           input logic [31:0] seq);
    int waited = 0;
    while (!bus.trace_valid_o && waited < 10) begin
      step();
      waited++;
    end
    check({tag, "_valid"}, bus.trace_valid_o, 1);
    check({tag, "_pc"}, bus.trace_pc_o, pc);
    check({tag, "_pre"}, bus.trace_pre_pc_o, pre);
    check({tag, "_seq"}, bus.trace_seq_o, seq);
    bus.trace_ready_i = 1'b1;
    step();
    bus.trace_ready_i = 1'b0;
  endtask

  initial begin
    bus.clear_i = 1'b0;
    bus.commit_i = 1'b0;
    bus.commit_pc_i = '0;
    bus.commit_pre_pc_i = '0;
    bus.trace_ready_i = 1'b0;

    do_reset();
    check("rst_valid", bus.trace_valid_o, 0);
    check("rst_count", bus.fifo_count_o, 0);
    check("rst_commit_cnt", bus.commit_cnt_o, 0);
    check("rst_drop_cnt", bus.drop_cnt_o, 0);
    check("rst_overflow", bus.overflow_o, 0);
    check("rst_flow_err", bus.flow_err_o, 0);
    check("rst_err_pc", bus.err_pc_o, 0);
    check("rst_trace_pc", bus.trace_pc_o, 0);

    // basic chain
    commit(32'h8000_0000, 32'h8000_0004);
    commit(32'h8000_0004, 32'h8000_0008);
    commit(32'h8000_0008, 32'h8000_0100);
    check("chain_count", bus.fifo_count_o, 3);
    check("chain_commit_cnt", bus.commit_cnt_o, 3);
    check("chain_flow_err", bus.flow_err_o, 0);
    pop_check("chain0", 32'h8000_0000, 32'h8000_0004, 0);
    pop_check("chain1", 32'h8000_0004, 32'h8000_0008, 1);
    pop_check("chain2", 32'h8000_0008, 32'h8000_0100, 2);
    check("chain_empty", bus.fifo_count_o, 0);

    // wrong first PC
    do_reset();
    commit(32'h8000_0004, 32'h8000_0008);
    check("first_err", bus.flow_err_o, 1);
    check("first_err_pc", bus.err_pc_o, 32'h8000_0004);
    check("first_err_exp", bus.err_exp_pc_o, 32'h8000_0000);
    check("first_count", bus.fifo_count_o, 0);
    commit(32'h8000_0000, 32'h8000_0004);
    check("first_ignored_cnt", bus.commit_cnt_o, 0);
    check("first_ignored_count", bus.fifo_count_o, 0);
    check("first_err_pc_hold", bus.err_pc_o, 32'h8000_0004);

    // break in the middle of a chain
    do_reset();
    commit(32'h8000_0000, 32'h8000_0004);
    commit(32'h8000_0004, 32'h8000_0008);
    commit(32'h8000_0008, 32'h8000_000C);
    commit(32'h8000_0010, 32'h8000_0014);
    check("mid_err", bus.flow_err_o, 1);
    check("mid_err_pc", bus.err_pc_o, 32'h8000_0010);
    check("mid_err_exp", bus.err_exp_pc_o, 32'h8000_000C);
    check("mid_commit_cnt", bus.commit_cnt_o, 3);
    pop_check("mid0", 32'h8000_0000, 32'h8000_0004, 0);
    pop_check("mid1", 32'h8000_0004, 32'h8000_0008, 1);
    pop_check("mid2", 32'h8000_0008, 32'h8000_000C, 2);
    check("mid_empty", bus.fifo_count_o, 0);

    // overflow with the consumer stalled
    do_reset();
    for (int i = 0; i < 20; i++) commit(BASE + 4 * i, BASE + 4 * (i + 1));
    check("ovf_count", bus.fifo_count_o, 16);
    check("ovf_drop_cnt", bus.drop_cnt_o, 4);
    check("ovf_overflow", bus.overflow_o, 1);
    check("ovf_commit_cnt", bus.commit_cnt_o, 20);
    check("ovf_flow_err", bus.flow_err_o, 0);
    for (int i = 0; i < 16; i++) pop_check("ovf_drain", BASE + 4 * i, BASE + 4 * (i + 1), i);
    check("ovf_empty", bus.fifo_count_o, 0);

    // full FIFO with simultaneous push and pop every cycle
    do_reset();
    for (int i = 0; i < 16; i++) commit(BASE + 4 * i, BASE + 4 * (i + 1));
    check("flow_full", bus.fifo_count_o, 16);
    for (int k = 0; k < 8; k++) begin
      bus.commit_i = 1'b1;
      bus.commit_pc_i = BASE + 4 * (16 + k);
      bus.commit_pre_pc_i = BASE + 4 * (17 + k);
      bus.trace_ready_i = 1'b1;
      check("flow_head_seq", bus.trace_seq_o, k);
      step();
      check("flow_count", bus.fifo_count_o, 16);
    end
    bus.commit_i = 1'b0;
    bus.trace_ready_i = 1'b0;
    check("flow_drop_cnt", bus.drop_cnt_o, 0);
    check("flow_commit_cnt", bus.commit_cnt_o, 24);
    for (int i = 8; i < 24; i++) pop_check("flow_drain", BASE + 4 * i, BASE + 4 * (i + 1), i);

    // clear coinciding with a commit
    do_reset();
    for (int i = 0; i < 20; i++) commit(BASE + 4 * i, BASE + 4 * (i + 1));
    bus.clear_i = 1'b1;
    commit(BASE + 4 * 20, BASE + 4 * 21);
    bus.clear_i = 1'b0;
    check("clr_count", bus.fifo_count_o, 0);
    check("clr_valid", bus.trace_valid_o, 0);
    check("clr_commit_cnt", bus.commit_cnt_o, 0);
    check("clr_drop_cnt", bus.drop_cnt_o, 0);
    check("clr_overflow", bus.overflow_o, 0);
    check("clr_flow_err", bus.flow_err_o, 0);
    commit(32'h8000_0000, 32'h8000_0040);
    check("clr_restart_err", bus.flow_err_o, 0);
    check("clr_restart_cnt", bus.commit_cnt_o, 1);
    pop_check("clr_restart", 32'h8000_0000, 32'h8000_0040, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/commit_trace_monitor.md
Name: commit_trace_monitor

Overview:
- Sits directly downstream of the CPU top and consumes its retirement stream (commit, commit_pc, commit_pre_pc).
- Checks control-flow continuity: each retired PC must equal the next-PC reported by the previous retirement.
- Counts retirements and buffers trace records in a FIFO, which a debug or scoreboard agent drains over a valid/ready interface.

Parameters:
- DEPTH, 16, trace FIFO entries; power of two, at least 2.
- RESET_PC, 32'h8000_0000, PC required of the first retirement after reset or clear.
- CNT_W, 32, width of the sequence, commit and drop counters.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- clear_i  in  1  synchronous soft clear; same effect as rst, one cycle.
- commit_i  in  1  one instruction retires this cycle.
- commit_pc_i  in  32  PC of the retiring instruction.
- commit_pre_pc_i  in  32  architectural next PC of the retiring instruction.
- trace_valid_o  out  1  FIFO head valid.
- trace_ready_i  in  1  consumer accepts the head.
- trace_pc_o  out  32  head record PC.
- trace_pre_pc_o  out  32  head record next PC.
- trace_seq_o  out  CNT_W  head record sequence number.
- fifo_count_o  out  $clog2(DEPTH)+1  current occupancy.
- commit_cnt_o  out  CNT_W  retirements accepted.
- drop_cnt_o  out  CNT_W  records lost to a full FIFO.
- overflow_o  out  1  sticky; at least one drop has occurred.
- flow_err_o  out  1  sticky; a continuity error was detected.
- err_pc_o  out  32  commit_pc_i that caused the error.
- err_exp_pc_o  out  32  PC expected at the time of the error.

Behaviour:
- Reset or clear: all outputs 0, FIFO empty, expected PC = RESET_PC, state WAIT_FIRST. If clear_i coincides with commit_i, clear wins and the commit is ignored.
- FSM:
  - WAIT_FIRST: on commit, if pc == RESET_PC, accept and go to TRACK; else raise the error and go to ERROR.
  - TRACK: on commit, if pc == expected, accept; else raise the error and go to ERROR.
  - ERROR: terminal until rst or clear. Commits are ignored; counters freeze; the FIFO continues to drain.
- Accept: expected <= commit_pre_pc_i; commit_cnt increments, wrapping modulo 2^CNT_W; a record {pc, pre_pc, seq = commit_cnt value before increment} is pushed.
- Error: flow_err_o <= 1; err_pc_o <= commit_pc_i; err_exp_pc_o <= expected PC. The offending record is not pushed and not counted.
- FIFO is first-word-fall-through:
  - trace_valid_o = (count != 0); head fields are stable while valid and not popped.
  - Pop = trace_valid_o && trace_ready_i.
  - A push is written the cycle after acceptance, so it first appears at the head one cycle after the commit when the FIFO is empty.
- Full (count == DEPTH):
  - Push with simultaneous pop: both happen, count unchanged.
  - Push without pop: record dropped, drop_cnt increments, overflow_o <= 1; commit_cnt still increments and the expected PC still updates.
- Empty with simultaneous push: push only, no pop.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally; count is tracked separately.
- No combinational path from commit_i to any output; outputs are registers or FIFO head reads.

Test Plan:
- Reset, then commits at 0x80000000→0x80000004, 0x80000004→0x80000008, 0x80000008→0x80000100, with ready=1 → three records with seq 0,1,2, commit_cnt_o=3, flow_err_o=0.
- After reset, first commit pc=0x80000004 → flow_err_o=1, err_pc_o=0x80000004, err_exp_pc_o=0x80000000, fifo_count_o=0; further commits are ignored and commit_cnt_o stays 0.
- Valid chain, then commit pc=0x80000010 when 0x8000000C is expected → error latched with those two values; earlier records still drain with correct seq.
- ready=0 for 20 valid commits with DEPTH=16 → fifo_count_o=16, drop_cnt_o=4, overflow_o=1, commit_cnt_o=20; draining yields seq 0..15 in order.
- FIFO full and ready=1 with a continuous commit each cycle → no drops, count stays 16, sequence numbers stay contiguous.
- clear_i asserted mid-run in the same cycle as a commit → next cycle all counters and flags are 0, FIFO is empty, the commit is ignored, and a following commit at 0x80000000 is accepted as seq 0.
